// File: rtl/seg7_pkg.sv
// Shared segment-encoding constants and types for the 7-segment scan driver.
// Segment bit order is gfedcba, i.e. bit0 = a.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam seg_t hex_pattern [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex digit to active-high segment pattern lookup.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] code_i,
    output seg_t       seg_o
);

    assign seg_o = hex_pattern[code_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex 7-segment driver with double-buffered display data,
// leading-zero suppression, per-digit blank/dp and anti-ghosting dead time.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 1000,
    parameter bit          ACTIVE_LOW  = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    lz_en,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    update_pending,
    output logic                    frame_done
);

    localparam int unsigned PreW = $clog2(REFRESH_DIV);
    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PreW-1:0] PreLast = PreW'(REFRESH_DIV - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_DIGITS - 1);

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] codes;
        logic [NUM_DIGITS-1:0]   dp_m;
        logic [NUM_DIGITS-1:0]   blank_m;
        logic                    lz;
    } disp_t;

    logic [PreW-1:0]       pre_q, pre_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic                  pend_q, pend_d;
    disp_t                 pset_q, pset_d;
    disp_t                 act_q, act_d;
    disp_t                 in_set;
    logic                  wrap_q, fd_q;
    seg_t                  seg_q;
    logic                  dp_q;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  slot_end, boundary;
    logic [NUM_DIGITS-1:0] suppress;
    logic                  zero_run;
    logic [3:0]            code;
    logic                  dark, dp_sel;
    seg_t                  dec;

    assign in_set   = {digits, dp_mask, blank_mask, lz_en};
    assign slot_end = (pre_q == PreLast);
    assign boundary = slot_end && (idx_q == IdxLast);

    always_comb begin
        pre_d  = slot_end ? '0 : pre_q + 1'b1;
        idx_d  = idx_q;
        if (slot_end) begin
            idx_d = boundary ? '0 : idx_q + 1'b1;
        end
        pend_d = pend_q;
        pset_d = pset_q;
        act_d  = act_q;
        // A load landing on the boundary bypasses the pending buffer entirely.
        if (boundary) begin
            if (load) begin
                act_d  = in_set;
                pend_d = 1'b0;
            end else if (pend_q) begin
                act_d  = pset_q;
                pend_d = 1'b0;
            end
        end else if (load) begin
            pset_d = in_set;
            pend_d = 1'b1;
        end
    end

    always_comb begin
        suppress = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run    = zero_run && (act_q.codes[4*i +: 4] == 4'h0);
            suppress[i] = act_q.lz && zero_run;
        end
        code   = '0;
        dark   = 1'b0;
        dp_sel = 1'b0;
        an_d   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IdxW'(i)) begin
                code    = act_q.codes[4*i +: 4];
                dark    = act_q.blank_m[i] || suppress[i];
                dp_sel  = act_q.dp_m[i] && !act_q.blank_m[i];
                an_d[i] = (pre_q != '0);
            end
        end
    end

    seg7_hex_decode u_dec (
        .code_i (code),
        .seg_o  (dec)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q  <= '0;
            idx_q  <= '0;
            pend_q <= 1'b0;
            pset_q <= '0;
            act_q  <= '0;
            wrap_q <= 1'b0;
            fd_q   <= 1'b0;
            seg_q  <= '0;
            dp_q   <= 1'b0;
            an_q   <= '0;
        end else begin
            pre_q  <= pre_d;
            idx_q  <= idx_d;
            pend_q <= pend_d;
            pset_q <= pset_d;
            act_q  <= act_d;
            // Delay by two so the pulse lines up with digit 0's first registered cycle.
            wrap_q <= boundary;
            fd_q   <= wrap_q;
            an_q   <= an_d;
            seg_q  <= (dark || (pre_q == '0)) ? '0 : dec;
            dp_q   <= dp_sel && (pre_q != '0);
        end
    end

    assign seg            = seg_q ^ {7{ACTIVE_LOW}};
    assign dp             = dp_q ^ ACTIVE_LOW;
    assign an             = an_q ^ {NUM_DIGITS{ACTIVE_LOW}};
    assign update_pending = pend_q;
    assign frame_done     = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: expected slot contents are queued at
// load time and consumed frame by frame as the scan reaches each digit.
module tb_seg7_scan_driver;

    localparam int N  = 4;
    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        reset, rst_al;
    logic [15:0] digits;
    logic [3:0]  dp_mask, blank_mask;
    logic        lz_en, load;
    logic [6:0]  seg, seg_al;
    logic        dp, dp_al;
    logic [3:0]  an, an_al;
    logic        up, up_al, fd, fd_al;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t       sb_q[$];
    logic [6:0] cur_seg [N];
    logic       cur_dp  [N];

    always #5 clk = ~clk;

    seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .ACTIVE_LOW(1'b0)) dut (
        .clk            (clk),
        .reset          (reset),
        .digits         (digits),
        .dp_mask        (dp_mask),
        .blank_mask     (blank_mask),
        .lz_en          (lz_en),
        .load           (load),
        .seg            (seg),
        .dp             (dp),
        .an             (an),
        .update_pending (up),
        .frame_done     (fd)
    );

    seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .ACTIVE_LOW(1'b1)) dut_al (
        .clk            (clk),
        .reset          (rst_al),
        .digits         (digits),
        .dp_mask        (dp_mask),
        .blank_mask     (blank_mask),
        .lz_en          (lz_en),
        .load           (load),
        .seg            (seg_al),
        .dp             (dp_al),
        .an             (an_al),
        .update_pending (up_al),
        .frame_done     (fd_al)
    );

    function automatic logic [6:0] ref_hex(input logic [3:0] c);
        case (c)
            4'h0: ref_hex = 7'h3F;  4'h1: ref_hex = 7'h06;
            4'h2: ref_hex = 7'h5B;  4'h3: ref_hex = 7'h4F;
            4'h4: ref_hex = 7'h66;  4'h5: ref_hex = 7'h6D;
            4'h6: ref_hex = 7'h7D;  4'h7: ref_hex = 7'h07;
            4'h8: ref_hex = 7'h7F;  4'h9: ref_hex = 7'h6F;
            4'hA: ref_hex = 7'h77;  4'hB: ref_hex = 7'h7C;
            4'hC: ref_hex = 7'h39;  4'hD: ref_hex = 7'h5E;
            4'hE: ref_hex = 7'h79;  default: ref_hex = 7'h71;
        endcase
    endfunction

    task automatic push_frame(input logic [15:0] d, input logic [3:0] dpm,
                              input logic [3:0] bm, input logic lz);
        for (int i = 0; i < N; i++) begin
            exp_t        e;
            logic [15:0] upper;
            upper = d >> (4 * i);
            e.an  = 4'(1 << i);
            e.dp  = dpm[i] && !bm[i];
            if (bm[i] || (lz && i > 0 && upper == 16'h0)) e.seg = 7'h00;
            else e.seg = ref_hex(upper[3:0]);
            sb_q.push_back(e);
        end
    endtask

    // Called at a negedge; strobes load across exactly one posedge.
    task automatic drive_load(input logic [15:0] d, input logic [3:0] dpm,
                              input logic [3:0] bm, input logic lz);
        digits     = d;
        dp_mask    = dpm;
        blank_mask = bm;
        lz_en      = lz;
        load       = 1'b1;
        @(negedge clk);
        load       = 1'b0;
    endtask

    task automatic wait_fd(input string name);
        int cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (fd !== 1'b1 && cnt < 4 * N * RD);
        checks++;
        if (fd !== 1'b1) begin
            errors++;
            $display("FAIL %s frame_done timeout: got %b want 1", name, fd);
        end
    endtask

    task automatic check_frame(input string name);
        if (fd !== 1'b1) wait_fd(name);
        for (int d = 0; d < N; d++) begin
            exp_t e;
            if (d > 0) @(negedge clk);
            checks++;
            if (an !== 4'b0000) begin
                errors++;
                $display("FAIL %s dead d%0d: an=%b want 0000", name, d, an);
            end
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s scoreboard d%0d: got empty queue want entry", name, d);
                e = '0;
            end else begin
                e = sb_q.pop_front();
            end
            cur_seg[d] = e.seg;
            cur_dp[d]  = e.dp;
            for (int c = 1; c < RD; c++) begin
                @(negedge clk);
                checks++;
                if ({an, seg, dp} !== e) begin
                    errors++;
                    $display("FAIL %s d%0d c%0d: an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                             name, d, c, an, seg, dp, e.an, e.seg, e.dp);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; rst_al = 1'b1;
        digits = '0; dp_mask = '0; blank_mask = '0; lz_en = 1'b0; load = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({seg, dp, an, up, fd} !== 14'b0) begin
            errors++;
            $display("FAIL reset_state: seg=%h dp=%b an=%b up=%b fd=%b want all 0",
                     seg, dp, an, up, fd);
        end
        checks++;
        if (seg_al !== 7'h7F || dp_al !== 1'b1 || an_al !== 4'hF) begin
            errors++;
            $display("FAIL reset_active_low: seg=%h dp=%b an=%b want 7f 1 1111",
                     seg_al, dp_al, an_al);
        end
        checks++;
        if (up_al !== 1'b0 || fd_al !== 1'b0) begin
            errors++;
            $display("FAIL reset_al_flags: up=%b fd=%b want 0 0", up_al, fd_al);
        end
        reset = 1'b0; rst_al = 1'b0;
        @(negedge clk);
        checks++;
        if (an !== 4'b0000) begin
            errors++;
            $display("FAIL first_dead: an=%b want 0000", an);
        end
        for (int c = 1; c < RD; c++) begin
            @(negedge clk);
            checks++;
            if (an !== 4'b0001 || seg !== 7'h3F) begin
                errors++;
                $display("FAIL first_slot c%0d: an=%b seg=%h want 0001 3f", c, an, seg);
            end
        end
        @(negedge clk);
        checks++;
        if (an !== 4'b0000) begin
            errors++;
            $display("FAIL second_dead: an=%b want 0000", an);
        end
    endtask

    task automatic test_frame_load(input string name, input logic [15:0] d,
                                   input logic [3:0] dpm, input logic [3:0] bm,
                                   input logic lz);
        wait_fd(name);
        repeat (2) @(negedge clk);
        drive_load(d, dpm, bm, lz);
        push_frame(d, dpm, bm, lz);
        checks++;
        if (up !== 1'b1) begin
            errors++;
            $display("FAIL %s pending_set: got %b want 1", name, up);
        end
        check_frame(name);
        checks++;
        if (up !== 1'b0) begin
            errors++;
            $display("FAIL %s pending_clear: got %b want 0", name, up);
        end
    endtask

    task automatic test_back_to_back();
        int cnt = 0;
        int d   = 0;
        wait_fd("b2b");
        repeat (2) @(negedge clk);
        drive_load(16'hAAAA, 4'h0, 4'h0, 1'b0);
        checks++;
        if (up !== 1'b1) begin
            errors++;
            $display("FAIL b2b pending_first: got %b want 1", up);
        end
        drive_load(16'hFFFF, 4'h0, 4'h0, 1'b0);
        push_frame(16'hFFFF, 4'h0, 4'h0, 1'b0);
        checks++;
        if (up !== 1'b1) begin
            errors++;
            $display("FAIL b2b pending_second: got %b want 1", up);
        end
        while (fd !== 1'b1 && cnt < 2 * N * RD) begin
            if (an !== 4'b0000) begin
                for (int i = 0; i < N; i++) if (an[i]) d = i;
                checks++;
                if (seg !== cur_seg[d] || dp !== cur_dp[d]) begin
                    errors++;
                    $display("FAIL b2b hold d%0d: seg=%h dp=%b want %h %b",
                             d, seg, dp, cur_seg[d], cur_dp[d]);
                end
            end
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (up !== 1'b0) begin
            errors++;
            $display("FAIL b2b pending_after: got %b want 0", up);
        end
        check_frame("b2b");
    endtask

    task automatic test_boundary_load();
        wait_fd("bnd");
        // Park just before the next boundary edge.
        repeat (N * RD - 2) @(negedge clk);
        drive_load(16'hC0DE, 4'b0001, 4'h0, 1'b0);
        push_frame(16'hC0DE, 4'b0001, 4'h0, 1'b0);
        checks++;
        if (up !== 1'b0) begin
            errors++;
            $display("FAIL bnd pending: got %b want 0", up);
        end
        @(negedge clk);
        checks++;
        if (fd !== 1'b1) begin
            errors++;
            $display("FAIL bnd frame_done: got %b want 1", fd);
        end
        check_frame("bnd");
    endtask

    task automatic test_reset_midscan();
        wait_fd("rst_mid");
        repeat (3) @(negedge clk);
        drive_load(16'h9999, 4'hF, 4'h0, 1'b0);
        checks++;
        if (up !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid pending_set: got %b want 1", up);
        end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (up !== 1'b0 || an !== 4'b0000 || seg !== 7'h00 || dp !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid async: up=%b an=%b seg=%h dp=%b want 0 0000 00 0",
                     up, an, seg, dp);
        end
        @(negedge clk);
        reset = 1'b0;
        push_frame(16'h0000, 4'h0, 4'h0, 1'b0);
        check_frame("rst_mid");
    endtask

    task automatic test_active_low();
        int cnt = 0;
        while (an_al === 4'hF && cnt < 4 * N * RD) begin
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (!$onehot(~an_al)) begin
            errors++;
            $display("FAIL al_scan: an=%b want single low bit", an_al);
        end
        #2 rst_al = 1'b1;
        #1;
        checks++;
        if (seg_al !== 7'h7F || dp_al !== 1'b1 || an_al !== 4'hF) begin
            errors++;
            $display("FAIL al_async_reset: seg=%h dp=%b an=%b want 7f 1 1111",
                     seg_al, dp_al, an_al);
        end
        @(negedge clk);
        rst_al = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_frame_load("hex",   16'h1234, 4'h0, 4'h0, 1'b0);
        test_frame_load("lz",    16'h0070, 4'h0, 4'h0, 1'b1);
        test_frame_load("zero",  16'h0000, 4'h0, 4'h0, 1'b1);
        test_frame_load("masks", 16'h0500, 4'b1011, 4'b0100, 1'b1);
        test_back_to_back();
        test_boundary_load();
        test_reset_midscan();
        test_active_low();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
